// File: rtl/parity_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | parity_frame_checker: serial frame receiver with parity check, error count  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module parity_frame_checker #(
  parameter int DATA_W     = 3,
  parameter bit PARITY_ODD = 1'b0,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int               c_BCNT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_BCNT_W-1:0] c_LAST = c_BCNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [c_BCNT_W-1:0] bcnt_q, bcnt_d;
  logic                par_q, par_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                out_valid_q, out_valid_d;
  logic                parity_err_q, parity_err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                frame_err;

  assign frame_err = par_q ^ bit_in ^ PARITY_ODD;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bcnt_d       = bcnt_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    out_valid_d  = 1'b0;
    parity_err_d = parity_err_q;
    err_cnt_d    = err_cnt_q;

    // frame_start overrides any bit in the same cycle, including a parity bit
    if (frame_start) begin
      state_d = ST_DATA;
      shift_d = '0;
      bcnt_d  = '0;
      par_d   = 1'b0;
    end else begin
      case (state_q)
        ST_DATA: begin
          if (bit_valid) begin
            shift_d = DATA_W'({shift_q, bit_in});
            par_d   = par_q ^ bit_in;
            bcnt_d  = bcnt_q + 1'b1;
            if (bcnt_q == c_LAST) begin
              state_d = ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (bit_valid) begin
            state_d      = ST_IDLE;
            out_valid_d  = 1'b1;
            data_out_d   = shift_q;
            parity_err_d = frame_err;
            if (frame_err && (err_cnt_q != c_CNT_MAX)) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bcnt_q       <= '0;
      par_q        <= 1'b0;
      busy_q       <= 1'b0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcnt_q       <= bcnt_d;
      par_q        <= par_d;
      busy_q       <= busy_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_parity_frame_checker: even and odd instances on shared stimulus          |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_parity_frame_checker;

  localparam int DW = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_start = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;

  logic          e_busy, e_ov, e_err, o_busy, o_ov, o_err;
  logic [DW-1:0] e_data, o_data;
  logic [CW-1:0] e_cnt, o_cnt;

  parity_frame_checker #(.DATA_W(DW), .PARITY_ODD(1'b0), .CNT_W(CW)) u_even (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(e_busy), .data_out(e_data), .out_valid(e_ov), .parity_err(e_err), .err_cnt(e_cnt)
  );

  parity_frame_checker #(.DATA_W(DW), .PARITY_ODD(1'b1), .CNT_W(CW)) u_odd (
    .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in),
    .busy(o_busy), .data_out(o_data), .out_valid(o_ov), .parity_err(o_err), .err_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q_e[$];
  exp_t q_o[$];
  int   m_cnt_e = 0;
  int   m_cnt_o = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frame parity is the popcount of data plus parity bit
  task automatic push_expect(input logic [DW-1:0] d, input logic p);
    int   ones;
    logic err_e;
    ones  = $countones(d) + int'(p);
    err_e = (ones % 2) != 0;
    if (err_e && m_cnt_e < (1 << CW) - 1) m_cnt_e++;
    if (!err_e && m_cnt_o < (1 << CW) - 1) m_cnt_o++;
    q_e.push_back('{d: d, err: err_e, cnt: CW'(m_cnt_e)});
    q_o.push_back('{d: d, err: ~err_e, cnt: CW'(m_cnt_o)});
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst && e_ov) begin
      if (q_e.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL even_unexpected_out_valid: got data %0d, none expected at %0t", e_data, $time);
      end else begin
        x = q_e.pop_front();
        chk("even_data", int'(e_data), int'(x.d));
        chk("even_err", int'(e_err), int'(x.err));
        chk("even_cnt", int'(e_cnt), int'(x.cnt));
      end
    end
  end

  always @(negedge clk) begin
    exp_t x;
    if (!rst && o_ov) begin
      if (q_o.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL odd_unexpected_out_valid: got data %0d, none expected at %0t", o_data, $time);
      end else begin
        x = q_o.pop_front();
        chk("odd_data", int'(o_data), int'(x.d));
        chk("odd_err", int'(o_err), int'(x.err));
        chk("odd_cnt", int'(o_cnt), int'(x.cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    frame_start = 1'b1;
    bit_valid   = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    bit_valid = 1'b0;
    repeat (gap) tick();
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic frame(input logic [DW-1:0] d, input logic p, input int max_gap);
    logic [DW-1:0] dv;
    dv = d;
    start();
    for (int i = DW - 1; i >= 0; i--) send_bit(dv[i], max_gap);
    push_expect(d, p);
    send_bit(p, max_gap);
  endtask

  function automatic logic even_bit(input logic [DW-1:0] d);
    return ($countones(d) % 2) != 0;
  endfunction

  task automatic drain();
    repeat (3) tick();
    chk("even_queue_drained", q_e.size(), 0);
    chk("odd_queue_drained", q_o.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_busy", int'(e_busy), 0);
    chk("reset_out_valid", int'(e_ov), 0);
    chk("reset_data", int'(e_data), 0);
    chk("reset_err", int'(e_err), 0);
    chk("reset_cnt", int'(e_cnt), 0);
    chk("reset_odd_cnt", int'(o_cnt), 0);
    tick();
    rst = 1'b0;
    tick();

    // bit_valid while idle must be ignored
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);

    for (int w = 0; w < 8; w++) frame(DW'(w), even_bit(DW'(w)), 0);
    drain();
    chk("even_cnt_after_good", int'(e_cnt), 0);

    frame(3'b011, 1'b1, 0);
    frame(3'b101, 1'b0, 0);
    drain();
    chk("even_cnt_after_err", int'(e_cnt), 1);

    frame(3'b000, 1'b1, 3);
    frame(3'b111, 1'b1, 3);
    drain();

    for (int k = 0; k < 17; k++) frame(3'b001, 1'b0, 0);
    drain();
    chk("even_cnt_saturated", int'(e_cnt), 15);

    // Abort after two data bits, then a full frame
    start();
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    frame(3'b110, 1'b0, 1);
    drain();

    // Abort on the parity bit itself
    start();
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    frame_start = 1'b1;
    bit_valid   = 1'b1;
    bit_in      = 1'b0;
    tick();
    frame_start = 1'b0;
    bit_valid   = 1'b0;
    @(negedge clk);
    chk("busy_after_parity_abort", int'(e_busy), 1);
    tick();
    frame(3'b010, 1'b1, 0);
    drain();

    // Reset in the middle of the data phase
    start();
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_cnt_e = 0;
    m_cnt_o = 0;
    @(negedge clk);
    chk("busy_after_mid_reset", int'(e_busy), 0);
    chk("cnt_after_mid_reset", int'(e_cnt), 0);
    chk("odd_cnt_after_mid_reset", int'(o_cnt), 0);
    tick();
    frame(3'b100, 1'b0, 2);
    drain();

    // Randomized frames with occasional aborts
    for (int k = 0; k < 150; k++) begin
      rd = DW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        start();
        repeat ($urandom_range(0, DW)) send_bit(1'($urandom), 2);
      end
      frame(rd, 1'($urandom), 3);
      if ($urandom_range(0, 1) == 1) tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
